rps_round_judge: RTL and testbench

- Upstream stage of the win counter (block_counter2); it drives that block's win/player inputs.
- Collects one guess per player through a valid/ready handshake, judges the round, and emits a one-cycle win pulse plus the winner id. Ties emit a tie pulse instead, and the round is replayed.
- Optional forfeit timeout awards the round to the player who submitted if the other player never does.

---
 rtl/rps_pkg.sv | 23 ++
 rtl/rps_slot.sv | 46 ++++
 rtl/rps_round_judge.sv | 153 +++++++++++++++
 tb/tb_rps_round_judge.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round judge: guess encodings,
// judge FSM states and the beats relation.
package rps_pkg;

   localparam logic [1:0] ROCK     = 2'd0;
   localparam logic [1:0] PAPER    = 2'd1;
   localparam logic [1:0] SCISSORS = 2'd2;
   localparam logic [1:0] ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      JUDGE   = 2'd1,
      REPORT  = 2'd2
   } state_t;

   // Returns 1 when guess a defeats guess b; equal or illegal pairs return 0.
   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return ((a == PAPER)    && (b == ROCK))  ||
             ((a == SCISSORS) && (b == PAPER)) ||
             ((a == ROCK)     && (b == SCISSORS));
   endfunction

endpackage

// File: rtl/rps_slot.sv
// One player's guess slot: valid/ready acceptance, held guess, and a one-cycle
// pulse when an offered guess carries the illegal encoding.
module rps_slot
   import rps_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clear,
   input  logic       valid,
   input  logic [1:0] guess_in,
   output logic       ready,
   output logic       accept,
   output logic       full,
   output logic [1:0] guess,
   output logic       bad
);

   logic       full_reg;
   logic [1:0] guess_reg;
   logic       bad_reg;

   assign ready  = enable && !full_reg;
   assign accept = valid && ready && (guess_in != ILLEGAL);
   assign full   = full_reg;
   assign guess  = guess_reg;
   assign bad    = bad_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_reg  <= 1'b0;
         guess_reg <= ROCK;
         bad_reg   <= 1'b0;
      end else begin
         // Strobes while not ready are dropped silently, so only ready cycles can flag.
         bad_reg <= valid && ready && (guess_in == ILLEGAL);
         if (clear) begin
            full_reg <= 1'b0;
         end else if (accept) begin
            full_reg  <= 1'b1;
            guess_reg <= guess_in;
         end
      end
   end

endmodule

// File: rtl/rps_round_judge.sv
// Collects one guess per player, judges the round and reports win/tie pulses,
// with an optional forfeit when only one player submits within TIMEOUT cycles.
module rps_round_judge
   import rps_pkg::*;
#(
   parameter int TIMEOUT = 0,
   parameter int CNT_W   = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       p0_valid,
   input  logic [1:0] p0_guess_in,
   output logic       p0_ready,
   input  logic       p1_valid,
   input  logic [1:0] p1_guess_in,
   output logic       p1_ready,
   output logic [1:0] p0guess,
   output logic [1:0] p1guess,
   output logic       win,
   output logic       player,
   output logic       tie,
   output logic       forfeit,
   output logic       bad_guess
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic             win_reg, win_next;
   logic             tie_reg, tie_next;
   logic             forfeit_reg, forfeit_next;
   logic             player_reg, player_next;
   logic [1:0]       p0guess_reg, p0guess_next;
   logic [1:0]       p1guess_reg, p1guess_next;

   logic             slot_enable, slot_clear;
   logic [1:0]       valid_arr, ready_arr, accept_arr, full_arr, bad_arr, full_after;
   logic [1:0]       guess_in_arr [2];
   logic [1:0]       guess_arr    [2];

   assign valid_arr       = {p1_valid, p0_valid};
   assign guess_in_arr[0] = p0_guess_in;
   assign guess_in_arr[1] = p1_guess_in;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         rps_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .enable   (slot_enable),
            .clear    (slot_clear),
            .valid    (valid_arr[gi]),
            .guess_in (guess_in_arr[gi]),
            .ready    (ready_arr[gi]),
            .accept   (accept_arr[gi]),
            .full     (full_arr[gi]),
            .guess    (guess_arr[gi]),
            .bad      (bad_arr[gi])
         );
      end
   endgenerate

   // Slot occupancy as it will be after this edge, including same-edge acceptances.
   assign full_after  = full_arr | accept_arr;
   assign slot_enable = (state_reg == COLLECT);
   assign slot_clear  = (state_reg == REPORT);
   assign cnt_inc     = (|full_arr) ? (cnt_reg + CNT_ONE) : CNT_ONE;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      win_next     = 1'b0;
      tie_next     = 1'b0;
      forfeit_next = 1'b0;
      player_next  = player_reg;
      p0guess_next = p0guess_reg;
      p1guess_next = p1guess_reg;
      case (state_reg)
         COLLECT: begin
            if (&full_after) begin
               state_next = JUDGE;
               cnt_next   = '0;
            end else if (^full_after) begin
               cnt_next = cnt_inc;
               if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_C)) begin
                  // The lone submitter takes the round; last judged guesses stay shown.
                  state_next   = REPORT;
                  win_next     = 1'b1;
                  forfeit_next = 1'b1;
                  player_next  = full_after[1];
               end
            end else begin
               cnt_next = '0;
            end
         end
         JUDGE: begin
            state_next   = REPORT;
            p0guess_next = guess_arr[0];
            p1guess_next = guess_arr[1];
            if (guess_arr[0] == guess_arr[1]) begin
               tie_next = 1'b1;
            end else begin
               win_next    = 1'b1;
               player_next = !beats(guess_arr[0], guess_arr[1]);
            end
         end
         REPORT: begin
            state_next = COLLECT;
            cnt_next   = '0;
         end
         default: begin
            state_next = COLLECT;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= COLLECT;
         cnt_reg     <= '0;
         win_reg     <= 1'b0;
         tie_reg     <= 1'b0;
         forfeit_reg <= 1'b0;
         player_reg  <= 1'b0;
         p0guess_reg <= ROCK;
         p1guess_reg <= ROCK;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         win_reg     <= win_next;
         tie_reg     <= tie_next;
         forfeit_reg <= forfeit_next;
         player_reg  <= player_next;
         p0guess_reg <= p0guess_next;
         p1guess_reg <= p1guess_next;
      end
   end

   assign p0_ready  = ready_arr[0];
   assign p1_ready  = ready_arr[1];
   assign p0guess   = p0guess_reg;
   assign p1guess   = p1guess_reg;
   assign win       = win_reg;
   assign tie       = tie_reg;
   assign forfeit   = forfeit_reg;
   assign player    = player_reg;
   assign bad_guess = |bad_arr;

endmodule

// File: tb/tb_rps_round_judge.sv
// Directed bench for rps_round_judge: expected round results go into a queue
// when guesses are driven and are popped when a win/tie pulse appears.
module tb_rps_round_judge;
   import rps_pkg::*;

   localparam int TIMEOUT = 5;

   typedef struct packed {
      logic       tie;
      logic       win;
      logic       player;
      logic       forfeit;
      logic [1:0] p0g;
      logic [1:0] p1g;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       p0_valid, p1_valid;
   logic [1:0] p0_guess_in, p1_guess_in;
   logic       p0_ready, p1_ready;
   logic [1:0] p0guess, p1guess;
   logic       win, player, tie, forfeit, bad_guess;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   lat;

   always #5 clk = ~clk;

   rps_round_judge #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .p0_valid    (p0_valid),
      .p0_guess_in (p0_guess_in),
      .p0_ready    (p0_ready),
      .p1_valid    (p1_valid),
      .p1_guess_in (p1_guess_in),
      .p1_ready    (p1_ready),
      .p0guess     (p0guess),
      .p1guess     (p1guess),
      .win         (win),
      .player      (player),
      .tie         (tie),
      .forfeit     (forfeit),
      .bad_guess   (bad_guess)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic t, input logic w, input logic p, input logic f,
                           input logic [1:0] g0, input logic [1:0] g1);
      exp_t e;
      e.tie = t; e.win = w; e.player = p; e.forfeit = f; e.p0g = g0; e.p1g = g1;
      sb_q.push_back(e);
   endtask

   // Called at a negedge; holds the strobes across one rising edge.
   task automatic submit(input logic v0, input logic [1:0] g0, input logic v1, input logic [1:0] g1);
      p0_valid = v0; p0_guess_in = g0;
      p1_valid = v1; p1_guess_in = g1;
      @(negedge clk);
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, output int latency);
      exp_t e;
      latency = 0;
      while (!(win || tie) && latency < 10) begin
         @(negedge clk);
         latency++;
      end
      check({tag, "_pulse_seen"}, 32'(win | tie), 32'd1);
      check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_win"},     32'(win),     32'(e.win));
         check({tag, "_tie"},     32'(tie),     32'(e.tie));
         check({tag, "_player"},  32'(player),  32'(e.player));
         check({tag, "_forfeit"}, 32'(forfeit), 32'(e.forfeit));
         check({tag, "_p0guess"}, 32'(p0guess), 32'(e.p0g));
         check({tag, "_p1guess"}, 32'(p1guess), 32'(e.p1g));
         $display("round %s: win=%0b tie=%0b player=%0b forfeit=%0b p0guess=%0d p1guess=%0d",
                  tag, win, tie, player, forfeit, p0guess, p1guess);
      end
      @(negedge clk);
      check({tag, "_single_pulse"}, 32'({win, tie}), 32'd0);
      check({tag, "_ready_back"},   32'({p0_ready, p1_ready}), 32'd3);
   endtask

   initial begin
      rst = 1'b0;
      p0_valid = 1'b0; p0_guess_in = ROCK;
      p1_valid = 1'b0; p1_guess_in = ROCK;
      repeat (2) @(negedge clk);
      check("reset_ready",   32'({p0_ready, p1_ready}), 32'd3);
      check("reset_pulses",  32'({win, tie, forfeit, bad_guess}), 32'd0);
      check("reset_player",  32'(player), 32'd0);
      check("reset_guesses", 32'({p0guess, p1guess}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Same-edge submission, ROCK beats SCISSORS.
      push_exp(1'b0, 1'b1, 1'b0, 1'b0, ROCK, SCISSORS);
      submit(1'b1, ROCK, 1'b1, SCISSORS);
      check("r1_ready_drop", 32'({p0_ready, p1_ready}), 32'd0);
      wait_result("r1", lat);

      // p1 arrives on the very edge the counter reaches TIMEOUT: the judge path wins.
      submit(1'b1, PAPER, 1'b0, ROCK);
      check("r2_p0_held", 32'({p0_ready, p1_ready}), 32'd1);
      repeat (3) @(negedge clk);
      check("r2_no_early_win", 32'(win | forfeit), 32'd0);
      push_exp(1'b0, 1'b1, 1'b1, 1'b0, PAPER, SCISSORS);
      submit(1'b0, ROCK, 1'b1, SCISSORS);
      wait_result("r2", lat);

      // Tie keeps player, then a fresh round decides it.
      push_exp(1'b1, 1'b0, 1'b1, 1'b0, PAPER, PAPER);
      submit(1'b1, PAPER, 1'b1, PAPER);
      wait_result("r3_tie", lat);
      push_exp(1'b0, 1'b1, 1'b0, 1'b0, PAPER, ROCK);
      submit(1'b1, PAPER, 1'b1, ROCK);
      wait_result("r3_replay", lat);

      // Illegal guess is flagged and not accepted.
      submit(1'b1, ILLEGAL, 1'b0, ROCK);
      check("r4_bad_pulse", 32'(bad_guess), 32'd1);
      check("r4_p0_ready",  32'(p0_ready),  32'd1);
      @(negedge clk);
      check("r4_bad_clear", 32'(bad_guess), 32'd0);
      push_exp(1'b0, 1'b1, 1'b1, 1'b0, ROCK, PAPER);
      submit(1'b1, ROCK, 1'b1, PAPER);
      // Illegal strobe while not ready must be ignored.
      p1_valid = 1'b1; p1_guess_in = ILLEGAL;
      @(negedge clk);
      p1_valid = 1'b0;
      check("r4_bad_ignored", 32'(bad_guess), 32'd0);
      wait_result("r4", lat);

      // Forfeit: counter is 1 on the fill edge and reaches 5 four edges later.
      push_exp(1'b0, 1'b1, 1'b1, 1'b1, ROCK, PAPER);
      submit(1'b0, ROCK, 1'b1, ROCK);
      check("r5_slot_state", 32'({p0_ready, p1_ready}), 32'd2);
      wait_result("r5_forfeit", lat);
      check("r5_forfeit_latency", 32'(lat), 32'd4);

      // Reset during JUDGE: everything returns to reset values, no pulse.
      submit(1'b1, SCISSORS, 1'b1, PAPER);
      check("r6_in_judge", 32'({p0_ready, p1_ready}), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("r6_rst_ready",   32'({p0_ready, p1_ready}), 32'd3);
      check("r6_rst_player",  32'(player), 32'd0);
      check("r6_rst_guesses", 32'({p0guess, p1guess}), 32'd0);
      @(negedge clk);
      check("r6_no_pulse", 32'({win, tie, forfeit}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("r6_still_quiet", 32'({win, tie}), 32'd0);

      push_exp(1'b0, 1'b1, 1'b0, 1'b0, SCISSORS, PAPER);
      submit(1'b1, SCISSORS, 1'b1, PAPER);
      wait_result("r7", lat);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
